// File: rtl/log2_sched_pkg.sv
// Shared constants and types for the round-robin log2 scheduler.
// Operands are unsigned Q6.10; results are signed Q6.10 (6-bit integer, 10-bit fraction).
package log2_sched_pkg;
    localparam int LOG2_N_REQ    = 4;
    localparam int LOG2_DATA_W   = 16;
    localparam int LOG2_PIPE_LAT = 3;
    localparam int LOG2_INT_W    = 6;
    localparam int LOG2_FRAC_W   = 10;
    localparam int LOG2_RES_W    = LOG2_INT_W + LOG2_FRAC_W;

    // Integer field 6'b100000 is reserved to flag log2(0).
    localparam logic [LOG2_RES_W-1:0] LOG2_INVALID = 16'h8000;

    typedef logic [$clog2(LOG2_N_REQ)-1:0] tag_t;
endpackage

// File: rtl/stage1_log2_approx.sv
// Three-stage log2 datapath: capture, piecewise-linear log2, output register.
// All stages advance together on i_en; operands ride along untouched.
module stage1_log2_approx
    import log2_sched_pkg::*;
#(
    parameter int DATA_W = LOG2_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_in0,
    input  logic [DATA_W-1:0]     i_in1,
    output logic                  o_valid,
    output logic [LOG2_RES_W-1:0] o_log2,
    output logic [DATA_W-1:0]     o_in0_byp,
    output logic [DATA_W-1:0]     o_in1_byp
);
    localparam int STAGES = 3;

    logic [STAGES:1]       vld_pipe;
    logic [DATA_W-1:0]     s1_in0, s1_in1, s2_in0, s2_in1;
    logic [LOG2_RES_W-1:0] s2_log2;

    // Integer part is the leading-one position minus the input fraction width;
    // the fraction is the bits just below the leading one (linear mantissa).
    function automatic logic [LOG2_RES_W-1:0] log2_fx(input logic [DATA_W-1:0] x);
        int                     msb;
        logic [LOG2_FRAC_W-1:0] frac;
        logic [LOG2_INT_W-1:0]  ip;
        msb  = 0;
        frac = '0;
        for (int b = 0; b < DATA_W; b++)
            if (x[b]) msb = b;
        for (int f = 0; f < LOG2_FRAC_W; f++)
            if (msb - 1 - f >= 0) frac[LOG2_FRAC_W-1-f] = x[msb-1-f];
        ip = LOG2_INT_W'(msb - LOG2_FRAC_W);
        return (x == '0) ? LOG2_INVALID : {ip, frac};
    endfunction

    // Valid shift register moves in lockstep with the data stages.
    always_ff @(posedge i_clk) begin
        if (i_rst)     vld_pipe <= '0;
        else if (i_en) vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
    end

    // Data stages; cleared on reset so idle outputs read as zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_in0    <= '0;
            s1_in1    <= '0;
            s2_in0    <= '0;
            s2_in1    <= '0;
            s2_log2   <= '0;
            o_log2    <= '0;
            o_in0_byp <= '0;
            o_in1_byp <= '0;
        end else if (i_en) begin
            s1_in0    <= i_in0;
            s1_in1    <= i_in1;
            s2_log2   <= log2_fx(s1_in0);
            s2_in0    <= s1_in0;
            s2_in1    <= s1_in1;
            o_log2    <= s2_log2;
            o_in0_byp <= s2_in0;
            o_in1_byp <= s2_in1;
        end
    end

    assign o_valid = vld_pipe[STAGES];
endmodule

// File: rtl/log2_rr_scheduler.sv
// Round-robin arbiter feeding N_REQ requesters into one shared log2 pipeline.
// The whole pipeline stalls as a unit when a valid result is not accepted.
module log2_rr_scheduler
    import log2_sched_pkg::*;
#(
    parameter  int N_REQ    = LOG2_N_REQ,
    parameter  int DATA_W   = LOG2_DATA_W,
    parameter  int PIPE_LAT = LOG2_PIPE_LAT,
    localparam int TAG_W    = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(PIPE_LAT + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_in0,
    input  logic [N_REQ*DATA_W-1:0] i_in1,
    output logic [N_REQ-1:0]        o_gnt,
    output logic                    o_valid,
    output logic [TAG_W-1:0]        o_tag,
    output logic [LOG2_RES_W-1:0]   o_log2,
    output logic [DATA_W-1:0]       o_in0_byp,
    output logic [DATA_W-1:0]       o_in1_byp,
    input  logic                    i_out_ready,
    output logic [CNT_W-1:0]        o_inflight
);
    logic                           en, xfer, drain;
    logic [TAG_W-1:0]               ptr, gnt_idx;
    logic [PIPE_LAT-1:0][TAG_W-1:0] tag_pipe;
    logic [DATA_W-1:0]              sel_in0, sel_in1;

    assign en    = !(o_valid && !i_out_ready);
    assign drain = o_valid && i_out_ready;

    // First requester at or after ptr wins; index wrap is free since N_REQ is a power of two.
    always_comb begin
        logic [TAG_W-1:0] idx;
        idx     = '0;
        o_gnt   = '0;
        gnt_idx = '0;
        xfer    = 1'b0;
        if (en && !i_rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = ptr + TAG_W'(i);
                if (!xfer && i_req[idx]) begin
                    xfer         = 1'b1;
                    gnt_idx      = idx;
                    o_gnt[idx]   = 1'b1;
                end
            end
        end
    end

    assign sel_in0 = i_in0[gnt_idx*DATA_W +: DATA_W];
    assign sel_in1 = i_in1[gnt_idx*DATA_W +: DATA_W];

    // Pointer moves just past the winner after each transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst)     ptr <= '0;
        else if (xfer) ptr <= gnt_idx + TAG_W'(1);
    end

    // Tag travels beside the datapath so o_tag always names the current o_log2.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_pipe <= '0;
        end else if (en) begin
            tag_pipe[0] <= gnt_idx;
            for (int s = 1; s < PIPE_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    // Occupancy: up on transfer, down on accepted result, unchanged when both.
    always_ff @(posedge i_clk) begin
        if (i_rst)                o_inflight <= '0;
        else if (xfer && !drain)  o_inflight <= o_inflight + CNT_W'(1);
        else if (!xfer && drain)  o_inflight <= o_inflight - CNT_W'(1);
    end

    assign o_tag = tag_pipe[PIPE_LAT-1];

    stage1_log2_approx #(
        .DATA_W (DATA_W)
    ) u_dp (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (en),
        .i_valid   (xfer),
        .i_in0     (sel_in0),
        .i_in1     (sel_in1),
        .o_valid   (o_valid),
        .o_log2    (o_log2),
        .o_in0_byp (o_in0_byp),
        .o_in1_byp (o_in1_byp)
    );
endmodule

// File: doc/log2_rr_scheduler.md
LOG2_RR_SCHEDULER -- requirements
Module: log2_rr_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one log2 pipeline (power of two, 2..8).
REQ-002 Parameter DATA_W, default 16, operand width.
REQ-003 Parameter PIPE_LAT, default 3, datapath latency in enabled cycles.
REQ-004 Port i_clk  input  1  single clock, all logic rising-edge.
REQ-005 Port i_rst  input  1  reset, synchronous, active-high.
REQ-006 Port i_req  input  N_REQ  per-requester request; operands valid while high.
REQ-007 Port i_in0  input  N_REQ*DATA_W  packed log2 operands, requester k at [k*DATA_W +: DATA_W].
REQ-008 Port i_in1  input  N_REQ*DATA_W  packed bypass operands, same packing.
REQ-009 Port o_gnt  output  N_REQ  one-hot grant; transfer occurs when i_req[k] and o_gnt[k] are both high.
REQ-010 Port o_valid  output  1  result valid.
REQ-011 Port o_tag  output  clog2(N_REQ)  requester index of the current result.
REQ-012 Port o_log2  output  16  log2 result of the granted i_in0.
REQ-013 Port o_in0_byp / o_in1_byp  output  DATA_W each  operands carried alongside the result.
REQ-014 Port i_out_ready  input  1  downstream accepts the result when high.
REQ-015 Port o_inflight  output  clog2(PIPE_LAT+1)  count of valid entries in the pipeline.

Function
REQ-016 Pipeline enable SHALL be en = !(o_valid && !i_out_ready); all datapath and tag registers advance only when en is high.
REQ-017 o_gnt SHALL be combinational, at most one bit high, and all-zero when en is low or i_rst is high.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer ptr and wraps modulo N_REQ; the first requesting index wins.
REQ-019 After a transfer to index k, ptr SHALL become (k+1) mod N_REQ; with no transfer, ptr SHALL hold.
REQ-020 The granted requester's i_in0/i_in1 SHALL be muxed into the datapath with valid=1; with no grant, valid=0 and the operands are don't-care.
REQ-021 A tag shift register PIPE_LAT deep SHALL advance on en in lockstep with the datapath, so that o_tag always matches o_log2.
REQ-022 Latency SHALL be exactly PIPE_LAT cycles with no stall: transfer in cycle t gives o_valid in cycle t+3.
REQ-023 While stalled (en low), o_valid, o_tag, o_log2 and the bypass outputs SHALL hold stable.
REQ-024 o_inflight SHALL increment on a transfer and decrement when o_valid && i_out_ready; simultaneous events SHALL leave it unchanged.
REQ-025 A zero operand SHALL yield o_log2 = 16'h8000 (integer field 6'b100000 marks an invalid result), and the result SHALL pass through normally.
REQ-026 A full pipeline with a blocked output SHALL grant nothing, and no result SHALL be dropped or duplicated.

Reset
REQ-027 When i_rst is high at a clock edge, ptr, all pipeline valids, tags and o_inflight SHALL clear to 0.
REQ-028 Reset-time outputs SHALL be o_valid=0, o_gnt=0, o_tag=0, o_log2=0, bypass outputs 0.
REQ-029 Reset mid-operation SHALL discard all in-flight results; none SHALL appear after reset deasserts.

Structure
REQ-030 Package log2_sched_pkg SHALL hold DATA_W, PIPE_LAT, the invalid-result constant 16'h8000 and the tag typedef.
REQ-031 The datapath SHALL be one instance of the team's 3-stage log2 pipeline (stage1_log2_approx), with i_en driven by en; the arbiter, tag shift register and counter SHALL live in log2_rr_scheduler.

Verification
REQ-032 Drive req=4'b0001 with in0[0]=16'h4000 for one cycle -> gnt=0001; 3 cycles later o_valid=1, o_tag=0, o_log2=16'h1000.
REQ-033 Hold req=4'b1111 continuously with ready=1 -> grants cycle 0,1,2,3,0,...; output tags appear in the same order, one per cycle.
REQ-034 Send in0[2]=16'h0800, then in0[1]=16'h0000 -> results 16'h0400 (tag 2), then 16'h8000 (tag 1).
REQ-035 Issue 3 requests with i_out_ready=0 -> pipeline fills, o_inflight=3, gnt=0, outputs held; raise ready -> 3 results in order, o_inflight returns to 0.
REQ-036 Assert i_rst with o_inflight=2 -> next cycle o_valid=0, o_inflight=0, ptr=0; no stale result after release.
